// File: rtl/boron_encoder.sv
// -----------------------------------------------------------------------------
// boron_encoder
//   Iterative BORON block-cipher encryptor. It takes a 64-bit block and an
//   80-bit key and runs one round per clock. Round keys are derived on the fly
//   in the forward direction, so there is no key pre-expansion phase. It uses
//   the same Start/done handshake as the BORON decryptor.
//
//   Ports
//     clk        : rising-edge clock
//     reset      : asynchronous, active-low reset
//     Start      : encrypt request, sampled only in IDLE
//     Plaintext  : 64-bit block, captured on the accepting edge
//     KEY0       : 80-bit user key, captured on the accepting edge
//     busy       : high from the accept edge until done is driven
//     done       : one-cycle pulse; Ciphertext is valid while it is high
//     Ciphertext : encrypted block
//
//   Build option
//     BORON_ENC_CT_HOLD_EN : when defined, Ciphertext holds the last result
//                            through FIN and IDLE. When undefined, Ciphertext
//                            reads all-ones whenever done is low.
// -----------------------------------------------------------------------------
module boron_encoder #(
    parameter int unsigned NROUNDS = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [63:0] Plaintext,
    input  logic [79:0] KEY0,
    output logic        busy,
    output logic        done,
    output logic [63:0] Ciphertext
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    localparam logic [4:0] LP_RC_LAST = 5'(NROUNDS - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [63:0] r_st;
    logic [79:0] r_key;
    logic [4:0]  r_rc;
    logic        r_busy;
    logic        r_done;
    logic [63:0] r_ct;

    logic        w_accept;
    logic        w_last;
    logic [4:0]  w_rc_inc;
    logic [63:0] w_round;
    logic [79:0] w_key_nxt;

    function automatic logic [3:0] f_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hE;  4'h1: y = 4'h4;  4'h2: y = 4'hB;  4'h3: y = 4'h1;
            4'h4: y = 4'h7;  4'h5: y = 4'h9;  4'h6: y = 4'hC;  4'h7: y = 4'hA;
            4'h8: y = 4'hD;  4'h9: y = 4'h2;  4'hA: y = 4'h0;  4'hB: y = 4'hF;
            4'hC: y = 4'h8;  4'hD: y = 4'h5;  4'hE: y = 4'h3;  default: y = 4'h6;
        endcase
        return y;
    endfunction

    // S-box layer, byte shuffle, per-word rotations, then the XOR layer.
    function automatic logic [63:0] f_round(input logic [63:0] s);
        logic [63:0] sb;
        logic [63:0] sh;
        logic [15:0] w0, w1, w2, w3;
        for (int unsigned i = 0; i < 16; i++) begin
            sb[4*i +: 4] = f_sbox(s[4*i +: 4]);
        end
        // Bytes B7..B0 are reordered to B5 B4 B7 B6 B1 B0 B3 B2.
        sh = {sb[47:32], sb[63:48], sb[15:0], sb[31:16]};
        w0 = {sh[14:0],  sh[15]};
        w1 = {sh[27:16], sh[31:28]};
        w2 = {sh[40:32], sh[47:41]};
        w3 = {sh[54:48], sh[63:55]};
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w0;
        return {w3, w2, w1, w0};
    endfunction

    // Forward key step. It is the inverse of the decryptor's key step.
    function automatic logic [79:0] f_ks(input logic [79:0] k, input logic [4:0] i);
        logic [79:0] t;
        t        = {k[66:0], k[79:67]};
        t[3:0]   = f_sbox(t[3:0]);
        t[63:59] = t[63:59] ^ i;
        return t;
    endfunction

    always_comb begin
        w_rc_inc  = r_rc + 5'd1;
        w_round   = f_round(r_st ^ r_key[63:0]);
        w_key_nxt = f_ks(r_key, w_rc_inc);
        w_accept  = (r_state == S_IDLE) && Start;
        w_last    = (r_state == S_RUN) && (r_rc == LP_RC_LAST);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (Start)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_st   <= '0;
            r_key  <= '0;
            r_rc   <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_ct   <= '1;
        end else begin
            if (w_accept) begin
                r_st   <= Plaintext;
                r_key  <= KEY0;
                r_rc   <= '0;
                r_busy <= 1'b1;
            end else if (r_state == S_RUN) begin
                r_st  <= w_round;
                r_key <= w_key_nxt;
                if (w_last) begin
                    // Output whitening with the final round key.
                    r_ct   <= w_round ^ w_key_nxt[63:0];
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end else begin
                    r_rc <= w_rc_inc;
                end
            end else if (r_state == S_FIN) begin
                r_done <= 1'b0;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;

`ifdef BORON_ENC_CT_HOLD_EN
    assign Ciphertext = r_ct;
`else
    assign Ciphertext = r_done ? r_ct : '1;
`endif

endmodule
